// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the aluop encodings for the load/store micro-ops, the word/byte
// constants used by the datapath, and small decode helpers that classify
// an aluop by access size and direction.
package mem_lsu_pkg;

    localparam int          ByteWidth = 8;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_size_e;

    function automatic acc_size_e acc_size(input logic [7:0] aluop);
        case (aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:                    return ACC_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:                    return ACC_HALF;
            EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP:          return ACC_WORD;
            default:                                             return ACC_NONE;
        endcase
    endfunction

    function automatic logic is_load(input logic [7:0] aluop);
        return (aluop == EXE_LB_OP) || (aluop == EXE_LBU_OP) ||
               (aluop == EXE_LH_OP) || (aluop == EXE_LHU_OP) ||
               (aluop == EXE_LW_OP) || (aluop == EXE_LL_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] aluop);
        return (aluop == EXE_SB_OP) || (aluop == EXE_SH_OP) ||
               (aluop == EXE_SW_OP) || (aluop == EXE_SC_OP);
    endfunction

    function automatic logic is_signed_load(input logic [7:0] aluop);
        return (aluop == EXE_LB_OP) || (aluop == EXE_LH_OP);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering for the memory stage (big-endian lanes:
// sel[3] / bits 31:24 hold byte offset 0).
// Ports:
//   aluop    in  8   operation code
//   offset   in  2   byte offset within the word
//   sdata    in  32  store source value
//   rdata    in  32  RAM read word
//   sel      out 4   byte-lane selects
//   wdata    out 32  lane-replicated store data
//   ldata    out 32  aligned, extended load result
//   misalign out 1   access not naturally aligned for its size
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  offset,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [ByteWidth-1:0] byte_lane;
    logic [15:0]          half_lane;
    logic                 sext;

    // Offset o lives in bits (31-8o):(24-8o); ~offset equals 3-o for 2 bits.
    assign byte_lane = rdata[{~offset, 3'b000} +: ByteWidth];
    assign half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
    assign sext      = is_signed_load(aluop);

    always_comb begin
        sel      = 4'b0000;
        wdata    = ZeroWord;
        ldata    = ZeroWord;
        misalign = 1'b0;
        case (acc_size(aluop))
            ACC_BYTE: begin
                sel   = 4'b1000 >> offset;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sext & byte_lane[7]}}, byte_lane};
            end
            ACC_HALF: begin
                misalign = offset[0];
                sel      = offset[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{sdata[15:0]}};
                ldata    = {{16{sext & half_lane[15]}}, half_lane};
            end
            ACC_WORD: begin
                misalign = |offset;
                sel      = 4'b1111;
                wdata    = sdata;
                ldata    = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MIPS32 memory-access stage: drives the data RAM combinationally from the
// EX/MEM operands, maintains the LL/SC link bit, flags misaligned accesses
// and owns the MEM/WB pipeline register.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   stall, flush           hold / clear the MEM/WB register and link bit
//   ex_*                   operands from the EX/MEM boundary
//   ram_ce/we/addr/sel/wdata, ram_rdata   data RAM interface
//   wb_wd/wreg/wdata       registered write-back result
//   llbit                  link bit
//   excp_adel/excp_ades    registered load/store address errors
//   badvaddr               registered faulting address
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        llbit,
    output logic        excp_adel,
    output logic        excp_ades,
    output logic [31:0] badvaddr
);

    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_misalign;

    mem_align u_align (
        .aluop    (ex_aluop),
        .offset   (ex_addr[1:0]),
        .sdata    (ex_sdata),
        .rdata    (ram_rdata),
        .sel      (al_sel),
        .wdata    (al_wdata),
        .ldata    (al_ldata),
        .misalign (al_misalign)
    );

    logic op_ld, op_st, op_ll, op_sc, op_mem, sc_ok, access_ok;

    logic [4:0]  wb_wd_q,    wb_wd_d;
    logic        wb_wreg_q,  wb_wreg_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;
    logic        llbit_q,    llbit_d;
    logic        adel_q,     adel_d;
    logic        ades_q,     ades_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    assign op_ld  = is_load(ex_aluop);
    assign op_st  = is_store(ex_aluop);
    assign op_ll  = (ex_aluop == EXE_LL_OP);
    assign op_sc  = (ex_aluop == EXE_SC_OP);
    assign op_mem = op_ld | op_st;

    // A failed SC (link lost) must not touch the RAM at all.
    assign sc_ok     = !op_sc || llbit_q;
    assign access_ok = op_mem && !al_misalign && sc_ok;

    assign ram_ce    = access_ok;
    // Stalled stores are re-presented later, so only the unstalled cycle writes.
    assign ram_we    = access_ok && op_st && !stall;
    assign ram_addr  = {ex_addr[31:2], 2'b00};
    assign ram_sel   = op_mem ? al_sel : 4'b0000;
    assign ram_wdata = op_st ? al_wdata : ZeroWord;

    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wreg_d  = wb_wreg_q;
        wb_wdata_d = wb_wdata_q;
        llbit_d    = llbit_q;
        adel_d     = adel_q;
        ades_d     = ades_q;
        badvaddr_d = badvaddr_q;
        if (flush) begin
            wb_wd_d    = 5'd0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = ZeroWord;
            llbit_d    = 1'b0;
            adel_d     = 1'b0;
            ades_d     = 1'b0;
        end else if (!stall) begin
            wb_wd_d    = ex_wd;
            wb_wreg_d  = ex_wreg;
            wb_wdata_d = ex_wdata;
            adel_d     = 1'b0;
            ades_d     = 1'b0;
            if (op_mem && al_misalign) begin
                // Faulting access: no write-back, link bit untouched.
                wb_wreg_d  = 1'b0;
                wb_wdata_d = ZeroWord;
                adel_d     = op_ld;
                ades_d     = op_st;
                badvaddr_d = ex_addr;
            end else if (op_ld) begin
                wb_wdata_d = al_ldata;
                if (op_ll) begin
                    llbit_d = 1'b1;
                end
            end else if (op_sc) begin
                wb_wdata_d = {31'd0, llbit_q};
                llbit_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wd_q    <= 5'd0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= ZeroWord;
            llbit_q    <= 1'b0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            badvaddr_q <= ZeroWord;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            llbit_q    <= llbit_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign wb_wd     = wb_wd_q;
    assign wb_wreg   = wb_wreg_q;
    assign wb_wdata  = wb_wdata_q;
    assign llbit     = llbit_q;
    assign excp_adel = adel_q;
    assign excp_ades = ades_q;
    assign badvaddr  = badvaddr_q;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the MIPS32 pipeline, sitting directly upstream of the data RAM. It turns load/store micro-ops from the EX/MEM boundary into RAM chip-enable, write-enable, word address, byte selects and lane-replicated store data. It aligns and sign- or zero-extends read data, maintains the LL/SC link bit, and detects misaligned accesses. It owns the MEM/WB pipeline register, so every result reaches write-back one cycle later.

## Interface
Parameters:
- none (widths fixed: 32-bit data/address, 5-bit register index, 8-bit aluop)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold MEM/WB register; suppress RAM write and link-bit update
- flush  in  1  clear MEM/WB register and link bit
- ex_aluop  in  8  operation code: LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC, or any other (pass-through)
- ex_addr  in  32  effective byte address
- ex_sdata  in  32  store source register value
- ex_wd  in  5  destination register
- ex_wreg  in  1  destination write enable
- ex_wdata  in  32  non-memory result (pass-through)
- ram_ce  out  1  RAM chip enable (combinational)
- ram_we  out  1  RAM write enable (combinational)
- ram_addr  out  32  word-aligned address, {ex_addr[31:2],2'b00}
- ram_sel  out  4  byte-lane selects, big-endian (sel[3] = bits 31:24 = byte offset 0)
- ram_wdata  out  32  store data, lane-replicated
- ram_rdata  in  32  RAM read data, combinational, same cycle
- wb_wd  out  5  registered destination
- wb_wreg  out  1  registered write enable
- wb_wdata  out  32  registered result
- llbit  out  1  link bit
- excp_adel  out  1  registered load address error
- excp_ades  out  1  registered store address error
- badvaddr  out  32  registered faulting address

## Operation
Byte offset is `o = ex_addr[1:0]`.

Byte access:
- ram_sel = 4'b1000 >> o
- Store data = {4{sdata[7:0]}}
- Load picks lane (3-o); LB sign-extends, LBU zero-extends.

Halfword access:
- ram_sel = 4'b1100 when o=0, 4'b0011 when o=2
- Store data = {2{sdata[15:0]}}
- Load: LH sign-extends, LHU zero-extends.

Word access (LW, SW, LL, SC):
- ram_sel = 4'b1111; data passes straight through.

Misalignment:
- Halfword with o[0]=1, or word with o≠0, is misaligned.
- Effects: ram_ce=0, ram_we=0, wb_wreg=0, excp_adel (loads, LL) or excp_ades (stores, SC) = 1, badvaddr = ex_addr.

LL:
- Performs a word load; llbit ← 1.

SC:
- If llbit=1: store the word, wb_wdata = 1, llbit ← 0.
- If llbit=0: ram_we=0, ram_ce=0, wb_wdata = 0.
- wb_wreg follows ex_wreg in both cases.

Non-memory op:
- ram_ce=0, ram_we=0, ram_sel=0, ram_wdata=0
- wb_* takes ex_* unchanged.

## Timing
- Reset: all registered outputs, llbit and badvaddr = 0.
- RAM signals are combinational from ex_* in the same cycle; the RAM writes at the rising edge ending that cycle.
- Latency: one cycle from ex_* to wb_*; one op per cycle.
- ram_we is forced to 0 whenever stall=1. The instruction is re-presented by upstream, so each store commits exactly once.
- Priority at a clock edge: flush > stall > normal.
  - flush: wb_*, excp_* → 0 and llbit → 0.
  - stall: all registers hold, llbit holds.
- SC decision uses the pre-edge llbit. For LL followed immediately by SC, the SC sees llbit=1.
- A misaligned SC does not clear llbit; a misaligned LL does not set it.
- Reset mid-stall: all registers clear immediately (asynchronous).

## Structure
- Aluop codes belong in the shared defines file alongside the existing EXE_*_OP set:
  - add EXE_LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC_OP if absent
  - keep ByteWidth/ZeroWord usage.
- One natural sub-module: `mem_align`, purely combinational. Inputs: aluop, offset, sdata, rdata. Outputs: sel, wdata, load result, misalign flag.
- Top level holds the llbit and MEM/WB registers.

## Test plan
- SB at 0x13 with sdata 0x000000A5 → ram_sel=0001, ram_wdata=A5A5A5A5, ram_we=1. Then LB at 0x13 → wb_wdata=FFFFFFA5; LBU at 0x13 → 000000A5.
- SH at 0x22 with sdata 0x8001 → ram_sel=0011. Then LH at 0x22 → wb_wdata=FFFF8001 one cycle later.
- LW at 0x21 → ram_ce=0, excp_adel=1, badvaddr=0x21, wb_wreg=0. SW at 0x22 → excp_ades=1, ram_we=0.
- LL at 0x40, then SC to 0x40 with 0x12345678 → store occurs, wb_wdata=1, llbit=0. Second SC → ram_we=0, wb_wdata=0.
- LL, then flush, then SC → SC fails (wb_wdata=0). Flush and stall in the same cycle → wb cleared.
- SW with stall=1 for 3 cycles → ram_we=0 throughout, wb_* held. Stall released → single write committed. Async rst mid-sequence → all outputs 0 before the next edge.
